// File: rtl/mem_pkg.sv
// Shared definitions for the data-RAM request path: default geometry, controller
// state encoding and the error-reason enumeration used by RAM-facing blocks.
package mem_pkg;

    localparam int unsigned DATA_WIDTH_DEF   = 64;
    localparam int unsigned ADDR_WIDTH_DEF   = 10;
    localparam logic [31:0] BASE_ADDRESS_DEF = 32'h0000_1000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_RANGE     = 2'd1,
        ERR_MISALIGN  = 2'd2
    } err_reason_e;

endpackage

// File: rtl/mem_addr_decode.sv
// Byte-address to RAM word-index decoder with range and alignment qualification.
// Purely combinational so it can be shared by every port that addresses the RAM.
module mem_addr_decode
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter logic [31:0] BASE_ADDRESS = BASE_ADDRESS_DEF
) (
    input  logic [31:0]           req_addr_i,
    output logic [ADDR_WIDTH-1:0] word_idx_o,
    output logic                  in_range_o,
    output logic                  aligned_o
);

    // One bit wider than the address so the byte span cannot overflow.
    localparam logic [32:0] RAM_BYTES = 33'(1) << (ADDR_WIDTH + 3);

    logic [31:0] offset;

    assign offset     = req_addr_i - BASE_ADDRESS;
    assign in_range_o = (req_addr_i >= BASE_ADDRESS) && ({1'b0, offset} < RAM_BYTES);
    assign aligned_o  = (req_addr_i[2:0] == 3'b000);
    assign word_idx_o = offset[ADDR_WIDTH+2:3];

endmodule

// File: rtl/mem_req_ctrl.sv
// Request-side controller for the single-port synchronous data RAM: one word per
// request, registered RAM controls, tri-state bus driven only during store ACCESS.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter logic [31:0] BASE_ADDRESS = BASE_ADDRESS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,

    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    cs_q, cs_d;
    logic                    we_q, we_d;
    logic                    oe_q, oe_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic [ADDR_WIDTH-1:0]   word_idx;
    logic                    in_range;
    logic                    aligned;
    logic                    legal;
    logic                    req_fire;

    mem_addr_decode #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .BASE_ADDRESS (BASE_ADDRESS)
    ) u_addr_decode (
        .req_addr_i (req_addr),
        .word_idx_o (word_idx),
        .in_range_o (in_range),
        .aligned_o  (aligned)
    );

    assign legal     = in_range && aligned;
    assign req_ready = (state_q == IDLE) && !reset;
    assign req_fire  = req_valid && req_ready;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it
        // unassigned; an unassigned path would infer a latch.
        state_d = state_q;
        addr_d  = addr_q;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        oe_d    = 1'b0;
        err_d   = err_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    rdata_d = '0;
                    err_d   = !legal;
                    wdata_d = req_wdata;
                    if (legal) begin
                        state_d = ACCESS;
                        addr_d  = word_idx;
                        cs_d    = 1'b1;
                        we_d    = req_we;
                        oe_d    = !req_we;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                // The RAM latched the word on the negedge inside this cycle.
                state_d = RESP;
                if (oe_q) begin
                    rdata_d = ram_data;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: store data is left unreset; it only reaches the bus while we_q is set,
    // which reset clears.
    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
    end

    assign ram_data    = we_q ? wdata_q : 'z;
    assign ram_address = addr_q;
    assign ram_cs      = cs_q;
    assign ram_we      = we_q;
    assign ram_oe      = oe_q;

    assign resp_valid  = (state_q == RESP);
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;

    a_we_oe_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(ram_we && ram_oe));

    a_cs_only_in_access: assert property (@(posedge clk) disable iff (reset)
        ram_cs |-> (state_q == ACCESS));

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: table of directed requests against a
// negedge-latching RAM model, plus backpressure and mid-access reset sequences.
module tb_mem_req_ctrl;
    import mem_pkg::*;

    localparam int DW = 64;
    localparam int AW = 10;
    localparam int NV = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid, req_we, resp_ready;
    logic          req_ready, resp_valid, resp_err;
    logic [31:0]   req_addr;
    logic [DW-1:0] req_wdata, resp_rdata;
    logic [AW-1:0] ram_address;
    logic          ram_cs, ram_we, ram_oe;
    wire  [DW-1:0] ram_data;

    int checks = 0;
    int failures = 0;
    int cs_pulses = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    mem_req_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .ram_address (ram_address),
        .ram_cs      (ram_cs),
        .ram_we      (ram_we),
        .ram_oe      (ram_oe),
        .ram_data    (ram_data)
    );

    // RAM model: writes and latches read data on the falling edge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;

    always @(negedge clk) begin
        if (ram_cs && ram_we) mem[ram_address] <= ram_data;
        if (ram_cs && ram_oe) ram_q <= mem[ram_address];
    end

    assign ram_data = (ram_cs && ram_oe) ? ram_q : 'z;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (ram_cs) cs_pulses++;
            check("mon_we_oe_excl", 64'(ram_we && ram_oe), 64'd0);
            if (ram_cs) check("mon_bus_known", 64'($isunknown(ram_data)), 64'd0);
            else        check("mon_bus_z", 64'(ram_data === 64'bz), 64'd1);
        end
    end

    typedef struct {
        logic          we;
        logic [31:0]   addr;
        logic [DW-1:0] wdata;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
        logic [AW-1:0] exp_idx;
    } vec_t;

    vec_t vecs [NV];

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int cs_before;
        wait_ready(tag);
        cs_before = cs_pulses;
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!v.exp_err) begin
            check({tag, "_access_cs"},   64'(ram_cs), 64'd1);
            check({tag, "_access_addr"}, 64'(ram_address), 64'(v.exp_idx));
            check({tag, "_access_we"},   64'(ram_we), 64'(v.we));
            check({tag, "_access_oe"},   64'(ram_oe), 64'(!v.we));
        end
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"},    64'(lat), 64'(v.exp_lat));
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
        check({tag, "_resp_err"},   64'(resp_err), 64'(v.exp_err));
        check({tag, "_resp_rdata"}, resp_rdata, v.exp_rdata);
        check({tag, "_resp_ctrl"},  64'({ram_cs, ram_we, ram_oe}), 64'd0);
        @(posedge clk); #1;
        check({tag, "_resp_done"},  64'(resp_valid), 64'd0);
        check({tag, "_cs_pulses"},  64'(cs_pulses - cs_before), v.exp_err ? 64'd0 : 64'd1);
    endtask

    initial begin
        vec_t v;
        int cs_before;

        vecs[0]  = '{1'b1, 32'h0000_1000, 64'hDEADBEEF_CAFEF00D, 1'b0, 64'h0, 2, 10'h000};
        vecs[1]  = '{1'b0, 32'h0000_1000, 64'h0, 1'b0, 64'hDEADBEEF_CAFEF00D, 2, 10'h000};
        vecs[2]  = '{1'b1, 32'h0000_2FF8, 64'h01234567_89ABCDEF, 1'b0, 64'h0, 2, 10'h3FF};
        vecs[3]  = '{1'b0, 32'h0000_2FF8, 64'h0, 1'b0, 64'h01234567_89ABCDEF, 2, 10'h3FF};
        vecs[4]  = '{1'b0, 32'h0000_3000, 64'h0, 1'b1, 64'h0, 1, 10'h000};
        vecs[5]  = '{1'b0, 32'h0000_0FF8, 64'h0, 1'b1, 64'h0, 1, 10'h000};
        vecs[6]  = '{1'b1, 32'h0000_1004, 64'h11112222_33334444, 1'b1, 64'h0, 1, 10'h000};
        vecs[7]  = '{1'b1, 32'h0000_1008, 64'hA5A5A5A5_5A5A5A5A, 1'b0, 64'h0, 2, 10'h001};
        vecs[8]  = '{1'b0, 32'h0000_1008, 64'h0, 1'b0, 64'hA5A5A5A5_5A5A5A5A, 2, 10'h001};
        vecs[9]  = '{1'b0, 32'h0000_1000, 64'h0, 1'b0, 64'hDEADBEEF_CAFEF00D, 2, 10'h000};
        vecs[10] = '{1'b0, 32'h0000_0000, 64'h0, 1'b1, 64'h0, 1, 10'h000};
        vecs[11] = '{1'b0, 32'hFFFF_FFF8, 64'h0, 1'b1, 64'h0, 1, 10'h000};
        vecs[12] = '{1'b0, 32'h0000_1001, 64'h0, 1'b1, 64'h0, 1, 10'h000};

        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = '0;
        resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err",   64'(resp_err), 64'd0);
        check("rst_ram_ctrl",   64'({ram_cs, ram_we, ram_oe}), 64'd0);
        check("rst_ram_addr",   64'(ram_address), 64'd0);
        check("rst_bus_z",      64'(ram_data === 64'bz), 64'd1);
        mon_en = 1'b1;
        reset  = 1'b0;
        @(posedge clk); #1;
        check("idle_req_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Backpressure: hold the load response for 5 cycles with a store pending.
        resp_ready = 1'b0;
        wait_ready("bp");
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_1000;
        @(posedge clk); #1;
        req_we    = 1'b1;
        req_wdata = 64'hBAD0BAD0_BAD0BAD0;
        @(posedge clk); #1;
        check("bp_resp_valid_rise", 64'(resp_valid), 64'd1);
        cs_before = cs_pulses;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp%0d_resp_valid", k), 64'(resp_valid), 64'd1);
            check($sformatf("bp%0d_resp_rdata", k), resp_rdata, 64'hDEADBEEF_CAFEF00D);
            check($sformatf("bp%0d_resp_err", k),   64'(resp_err), 64'd0);
            check($sformatf("bp%0d_req_ready", k),  64'(req_ready), 64'd0);
            check($sformatf("bp%0d_ram_cs", k),     64'(ram_cs), 64'd0);
        end
        check("bp_no_cs_pulse", 64'(cs_pulses - cs_before), 64'd0);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 64'(resp_valid), 64'd0);
        check("bp_release_ready", 64'(req_ready), 64'd1);
        v = '{1'b0, 32'h0000_1000, 64'h0, 1'b0, 64'hDEADBEEF_CAFEF00D, 2, 10'h000};
        run_vec(v, "bp_reload");

        // Reset asserted during the ACCESS cycle of a load.
        wait_ready("rsta");
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_2FF8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rsta_in_access", 64'(ram_cs), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rsta_state",      64'(dut.state_q), 64'(IDLE));
        check("rsta_resp_valid", 64'(resp_valid), 64'd0);
        check("rsta_ram_ctrl",   64'({ram_cs, ram_we, ram_oe}), 64'd0);
        check("rsta_ram_addr",   64'(ram_address), 64'd0);
        check("rsta_bus_z",      64'(ram_data === 64'bz), 64'd1);
        check("rsta_req_ready",  64'(req_ready), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rsta_after_ready", 64'(req_ready), 64'd1);
        check("rsta_after_valid", 64'(resp_valid), 64'd0);
        v = '{1'b0, 32'h0000_2FF8, 64'h0, 1'b0, 64'h01234567_89ABCDEF, 2, 10'h3FF};
        run_vec(v, "rsta_reload");

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Request-side controller for the single-port synchronous data RAM. It accepts load/store requests from the CPU pipeline on a valid/ready interface and translates byte addresses into RAM word indices. It drives the RAM chip-select, write-enable, output-enable and shared tri-state data bus, then returns read data or an error on a valid/ready response channel. It sits directly upstream of the RAM, which writes and latches read data on the falling clock edge.

## Interface
- DATA_WIDTH, 64, RAM word width; one request moves one full word.
- ADDR_WIDTH, 10, RAM word-index width; RAM_DEPTH = 1 << ADDR_WIDTH.
- BASE_ADDRESS, 32'h00001000, byte address of RAM word 0.
- clk  input  1  single clock; controller logic is posedge-only.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  DATA_WIDTH  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  DATA_WIDTH  load data; 0 for stores and errors.
- resp_err  output  1  request was out of range or misaligned.
- ram_address  output  ADDR_WIDTH  RAM word index.
- ram_cs, ram_we, ram_oe  output  1 each  RAM controls.
- ram_data  inout  DATA_WIDTH  shared RAM data bus.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid && req_ready, register the request:
  - Legal request: go to ACCESS.
  - Illegal request: go straight to RESP with resp_err=1 and resp_rdata=0. ram_cs is never asserted.
- Legal request conditions:
  - req_addr >= BASE_ADDRESS.
  - (req_addr - BASE_ADDRESS) < RAM_DEPTH*8.
  - req_addr[2:0] == 0.
  - ram_address = (req_addr - BASE_ADDRESS)[ADDR_WIDTH+2:3]. The 32-bit subtraction is unsigned; the range check is done before truncation.
- ACCESS (exactly one cycle): ram_cs=1 and ram_address is held.
  - Store: ram_we=1, ram_oe=0, controller drives req_wdata onto ram_data.
  - Load: ram_we=0, ram_oe=1, controller releases ram_data to Z.
  - Next state is always RESP. On a load, ram_data is captured into resp_rdata at the posedge that leaves ACCESS.
- RESP: resp_valid=1 and all RAM controls are 0. Hold resp_rdata and resp_err stable until resp_ready. On the handshake, go to IDLE.
- Bus rule: the controller drives ram_data only in ACCESS with a store. ram_we and ram_oe are never both 1. The bus is Z in every other state.
- All RAM control outputs are registered, with no combinational path from req_* to ram_*.

## Timing
- Reset values: req_ready=0 while reset is high; resp_valid=0, resp_rdata=0, resp_err=0, ram_cs=ram_we=ram_oe=0, ram_address=0, ram_data=Z. State is IDLE.
- Request accepted at edge E0:
  - ACCESS occupies E0..E1. The RAM writes or latches on the negedge inside that cycle.
  - resp_valid rises after E1, so response latency is 2 cycles.
- Error request accepted at E0: resp_valid rises after E0, so latency is 1 cycle.
- Throughput: at most one request per 3 cycles (IDLE, ACCESS, RESP), or per 2 cycles for errors.
- Backpressure: while resp_ready=0, stay in RESP. req_ready stays 0 and no new RAM access is issued.
- Reset mid-operation, sampled at a posedge: go to IDLE and drop any pending response.
  - A store whose ACCESS cycle contained a negedge has already committed. This is acceptable.
  - The bus is released within the same cycle as the reset edge.
- Last legal word is BASE_ADDRESS + (RAM_DEPTH-1)*8. The next aligned address is an error, not wrap-around.

## Structure
- Shared package mem_pkg holds:
  - BASE_ADDRESS, DATA_WIDTH and ADDR_WIDTH defaults.
  - The state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2).
  - An enumerated error reason, for future extension.
- One combinational sub-module, mem_addr_decode: takes req_addr and returns word index, in_range and aligned. It is reused by future instruction-fetch ports.
- The tri-state driver for ram_data lives in mem_req_ctrl.

## Test plan
- Store 64'hDEADBEEF_CAFEF00D at 0x1000, then load 0x1000 -> response resp_rdata=64'hDEADBEEF_CAFEF00D, resp_err=0, arriving 2 cycles after acceptance.
- Store and load at 0x2FF8 (last word) -> ram_address=10'h3FF and data returned intact. Load at 0x3000 -> resp_err=1 and ram_cs stays 0.
- Load at 0x0FF8 and store at 0x1004 -> resp_err=1, resp_rdata=0, ram_cs never asserted, 1-cycle latency.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid, resp_rdata and resp_err stay stable, req_ready stays 0, and no ram_cs pulse occurs.
- Assert reset during ACCESS of a load -> next cycle state is IDLE, resp_valid=0, all ram_* are 0, and ram_data is Z.
- Monitor ram_data over all tests -> never driven by both sides. Bus contention shows as X and the check fails on any X.
